// File: rtl/lsu_bus_bridge.sv
// Load/store unit to bus bridge.
// Converts one memory-stage access into a single bus transfer: lane steering,
// alignment check, grant/response handshake, timeout abort and pipeline stall.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_m_i,
  input  logic        mem_write_m_i,
  input  logic        mem_read_m_i,
  input  logic [31:0] alu_result_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [2:0]  width_src_m_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] read_data_m_o,
  output logic        stall_m_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  count;
  logic        access;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        timeout_hit;
  logic        start;
  logic        capture;
  logic        abort;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        unused_width_bit;

  // Width bit 2 (load sign handling) belongs to the writeback stage, not here.
  assign unused_width_bit = width_src_m_i[2];

  assign access      = valid_m_i & (mem_write_m_i | mem_read_m_i);
  assign is_half     = (width_src_m_i[1:0] == 2'b01);
  assign is_word     = width_src_m_i[1];
  assign misaligned  = (is_half & alu_result_m_i[0]) |
                       (is_word & (alu_result_m_i[1:0] != 2'b00));
  assign timeout_hit = (count == TIMEOUT_LAST);
  assign bus_req_o   = (state == REQ);

  // Steer the store data onto every lane and select the byte enables for the access width.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = write_data_m_i;
    case (width_src_m_i[1:0])
      2'b00: begin
        be_next    = 4'b0001 << alu_result_m_i[1:0];
        wdata_next = {4{write_data_m_i[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << {alu_result_m_i[1], 1'b0};
        wdata_next = {2{write_data_m_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state and handshake decode; a success event always wins over the timeout.
  always_comb begin
    state_next = state;
    stall_m_o  = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    start      = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stall_m_o  = 1'b1;
            start      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall_m_o = 1'b1;
        if (bus_gnt_i) begin
          state_next = bus_we_o ? DONE : WAIT;
        end else if (timeout_hit) begin
          bus_err_o  = 1'b1;
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      WAIT: begin
        stall_m_o = 1'b1;
        if (bus_rvalid_i) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          bus_err_o  = 1'b1;
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, latched access, timeout counter and load data registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state         <= IDLE;
      count         <= 8'd0;
      bus_we_o      <= 1'b0;
      bus_addr_o    <= 32'd0;
      bus_wdata_o   <= 32'd0;
      bus_be_o      <= 4'd0;
      read_data_m_o <= 32'd0;
    end else begin
      state <= state_next;
      if (start) begin
        count       <= 8'd0;
        bus_we_o    <= mem_write_m_i;
        bus_addr_o  <= {alu_result_m_i[31:2], 2'b00};
        bus_wdata_o <= wdata_next;
        bus_be_o    <= be_next;
      end else if (((state == REQ) || (state == WAIT)) && (count != 8'hFF)) begin
        count <= count + 8'd1;
      end
      if (capture) begin
        read_data_m_o <= bus_rdata_i;
      end else if (abort) begin
        read_data_m_o <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Testbench for lsu_bus_bridge: a transaction-level model turns each directed
// access into a per-cycle list of expected outputs that a compare process checks.
module tb_lsu_bus_bridge;

  localparam int TO = 4;

  typedef struct {
    logic        req;
    logic        stall;
    logic        mis;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    bit          chk_bus;
    bit          grant;
    string       tag;
  } exp_t;

  logic        clk;
  logic        reset_i;
  logic        valid_m_i;
  logic        mem_write_m_i;
  logic        mem_read_m_i;
  logic [31:0] alu_result_m_i;
  logic [31:0] write_data_m_i;
  logic [2:0]  width_src_m_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic [31:0] read_data_m_o;
  logic        stall_m_o;
  logic        misalign_o;
  logic        bus_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t        exp_q[$];
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] model_rdata;

  int          stall_tot = 0;
  int          req_tot = 0;
  int          mis_tot = 0;
  int          err_tot = 0;
  logic        snap_we;
  logic [31:0] snap_addr;
  logic [31:0] snap_wdata;
  logic [3:0]  snap_be;

  lsu_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .valid_m_i      (valid_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .mem_read_m_i   (mem_read_m_i),
    .alu_result_m_i (alu_result_m_i),
    .write_data_m_i (write_data_m_i),
    .width_src_m_i  (width_src_m_i),
    .bus_req_o      (bus_req_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_be_o       (bus_be_o),
    .bus_gnt_i      (bus_gnt_i),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i),
    .read_data_m_o  (read_data_m_o),
    .stall_m_o      (stall_m_o),
    .misalign_o     (misalign_o),
    .bus_err_o      (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // What the bus should carry for an aligned access, from size arithmetic.
  task automatic set_model(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] w_src);
    int size;
    size = (w_src[1:0] == 2'b00) ? 1 : (w_src[1:0] == 2'b01) ? 2 : 4;
    m_we   = wr;
    m_addr = (addr / 4) * 4;
    m_be   = 4'(((1 << size) - 1) << (addr % 4));
    if (size == 1)      m_wdata = 32'(wd[7:0]) * 32'h01010101;
    else if (size == 2) m_wdata = 32'(wd[15:0]) * 32'h00010001;
    else                m_wdata = wd;
  endtask

  task automatic push_exp(input logic req, input logic stall, input logic mis, input logic err,
                          input bit chk_bus, input bit grant, input bit zero, input string tag);
    exp_t e;
    e.req     = req;
    e.stall   = stall;
    e.mis     = mis;
    e.err     = err;
    e.we      = zero ? 1'b0  : m_we;
    e.addr    = zero ? 32'd0 : m_addr;
    e.wdata   = zero ? 32'd0 : m_wdata;
    e.be      = zero ? 4'd0  : m_be;
    e.rdata   = model_rdata;
    e.chk_bus = chk_bus | zero;
    e.grant   = grant;
    e.tag     = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid_m_i    = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
      tick();
    end
  endtask

  // One memory-stage access; gnt_dly/rv_dly count waiting cycles (-1 = never arrives).
  task automatic apply_stimulus(input logic wr, input logic rd, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [2:0] w_src,
                                input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                                input bit late_rv, input string tag);
    int size;
    int cyc;
    int w;
    bit mis;
    bit done;
    bit in_req;
    bit g;
    bit r;
    bit to;
    size = (w_src[1:0] == 2'b00) ? 1 : (w_src[1:0] == 2'b01) ? 2 : 4;
    mis  = (addr % size) != 0;
    valid_m_i      = 1'b1;
    mem_write_m_i  = wr;
    mem_read_m_i   = rd;
    alu_result_m_i = addr;
    write_data_m_i = wd;
    width_src_m_i  = w_src;
    bus_gnt_i      = 1'b0;
    bus_rvalid_i   = 1'b0;
    if (mis) begin
      push_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "/mis"});
      tick();
      valid_m_i = 1'b0;
      return;
    end
    set_model(wr, addr, wd, w_src);
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "/acc"});
    tick();
    // The stage keeps changing underneath the bridge; none of it may leak in.
    mem_write_m_i  = ~wr;
    mem_read_m_i   = 1'b1;
    alu_result_m_i = 32'hDEADBEE1;
    write_data_m_i = 32'h5A5A5A5A;
    width_src_m_i  = 3'b001;
    cyc    = 0;
    w      = 0;
    done   = 1'b0;
    in_req = 1'b1;
    for (int n = 0; n < 300 && !done; n++) begin
      if (in_req) begin
        g  = (cyc == gnt_dly);
        to = !g && (cyc == TO - 1);
        bus_gnt_i    = g;
        bus_rvalid_i = 1'b0;
        push_exp(1'b1, 1'b1, 1'b0, to, 1'b1, g, 1'b0, {tag, "/req"});
        tick();
        cyc++;
        if (to) begin
          model_rdata = 32'd0;
          done = 1'b1;
        end else if (g) begin
          if (wr) done = 1'b1;
          else in_req = 1'b0;
        end
      end else begin
        r  = (w == rv_dly);
        to = !r && (cyc == TO - 1);
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = r;
        bus_rdata_i  = r ? rdata : 32'hBAD0BAD0;
        push_exp(1'b0, 1'b1, 1'b0, to, 1'b0, 1'b0, 1'b0, {tag, "/wait"});
        tick();
        cyc++;
        w++;
        if (r) begin
          model_rdata = rdata;
          done = 1'b1;
        end else if (to) begin
          model_rdata = 32'd0;
          done = 1'b1;
        end
      end
    end
    valid_m_i    = 1'b0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = late_rv;
    bus_rdata_i  = 32'hFEEDFACE;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, "/done"});
    tick();
    bus_rvalid_i  = 1'b0;
    mem_write_m_i = 1'b0;
    mem_read_m_i  = 1'b0;
  endtask

  // Compare every expected cycle against the DUT on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      stall_tot += int'(stall_m_o === 1'b1);
      req_tot   += int'(bus_req_o === 1'b1);
      mis_tot   += int'(misalign_o === 1'b1);
      err_tot   += int'(bus_err_o === 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output({e.tag, "/req_o"},   32'(bus_req_o),  32'(e.req));
        check_output({e.tag, "/stall"},   32'(stall_m_o),  32'(e.stall));
        check_output({e.tag, "/misalign"},32'(misalign_o), 32'(e.mis));
        check_output({e.tag, "/bus_err"}, 32'(bus_err_o),  32'(e.err));
        check_output({e.tag, "/rdata"},   read_data_m_o,   e.rdata);
        if (e.chk_bus) begin
          check_output({e.tag, "/we"},    32'(bus_we_o),   32'(e.we));
          check_output({e.tag, "/addr"},  bus_addr_o,      e.addr);
          check_output({e.tag, "/be"},    32'(bus_be_o),   32'(e.be));
          check_output({e.tag, "/wdata"}, bus_wdata_o,     e.wdata);
        end
        if (e.grant) begin
          snap_we    = bus_we_o;
          snap_addr  = bus_addr_o;
          snap_wdata = bus_wdata_o;
          snap_be    = bus_be_o;
        end
      end
    end
  end

  initial begin
    int s0;
    int r0;
    int m0;
    int e0;
    reset_i        = 1'b0;
    valid_m_i      = 1'b0;
    mem_write_m_i  = 1'b0;
    mem_read_m_i   = 1'b0;
    alu_result_m_i = 32'd0;
    write_data_m_i = 32'd0;
    width_src_m_i  = 3'd0;
    bus_gnt_i      = 1'b0;
    bus_rvalid_i   = 1'b0;
    bus_rdata_i    = 32'd0;
    model_rdata    = 32'd0;
    m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_be = 4'd0;

    tick();
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    tick();
    reset_i = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset");
    tick();

    // A request without valid is not an access.
    valid_m_i = 1'b0; mem_read_m_i = 1'b1; alu_result_m_i = 32'h201; width_src_m_i = 3'b001;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "no_valid");
    tick();
    mem_read_m_i = 1'b0;

    // Store byte to 0x103, granted at once.
    s0 = stall_tot; r0 = req_tot;
    apply_stimulus(1'b1, 1'b0, 32'h103, 32'h000000AB, 3'b000, 0, -1, 32'd0, 1'b0, "sb103");
    check_output("sb103_be",     32'(snap_be), 32'h8);
    check_output("sb103_wdata",  snap_wdata, 32'hABABABAB);
    check_output("sb103_addr",   snap_addr, 32'h100);
    check_output("sb103_we",     32'(snap_we), 32'h1);
    check_output("sb103_stalls", 32'(stall_tot - s0), 32'd2);
    check_output("sb103_reqs",   32'(req_tot - r0), 32'd1);
    idle_cycles(1);

    // Load word from 0x200: grant on the 4th request cycle, data two cycles later.
    s0 = stall_tot; r0 = req_tot; e0 = err_tot;
    apply_stimulus(1'b0, 1'b1, 32'h200, 32'd0, 3'b010, 3, 1, 32'h12345678, 1'b1, "lw200");
    check_output("lw200_rdata",  read_data_m_o, 32'h12345678);
    check_output("lw200_stalls", 32'(stall_tot - s0), 32'd7);
    check_output("lw200_reqs",   32'(req_tot - r0), 32'd4);
    check_output("lw200_errs",   32'(err_tot - e0), 32'd0);
    idle_cycles(1);

    // Reset while waiting for load data; the late response must be dropped.
    valid_m_i = 1'b1; mem_read_m_i = 1'b1; mem_write_m_i = 1'b0;
    alu_result_m_i = 32'h400; write_data_m_i = 32'd0; width_src_m_i = 3'b010;
    set_model(1'b0, 32'h400, 32'd0, 3'b010);
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_wait/acc");
    tick();
    valid_m_i = 1'b0; bus_gnt_i = 1'b1;
    push_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rst_wait/req");
    tick();
    bus_gnt_i = 1'b0;
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_wait/wait");
    tick();
    reset_i = 1'b0;
    push_exp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_wait/in_reset");
    tick();
    reset_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77777777;
    model_rdata = 32'd0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_wait/after");
    tick();
    bus_rvalid_i = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_wait/after2");
    tick();

    // Misaligned half load and misaligned word store.
    s0 = stall_tot; r0 = req_tot; m0 = mis_tot;
    apply_stimulus(1'b0, 1'b1, 32'h201, 32'd0, 3'b001, 0, 0, 32'd0, 1'b0, "lh201");
    idle_cycles(2);
    check_output("lh201_mis",    32'(mis_tot - m0), 32'd1);
    check_output("lh201_reqs",   32'(req_tot - r0), 32'd0);
    check_output("lh201_stalls", 32'(stall_tot - s0), 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h102, 32'h1, 3'b010, 0, 0, 32'd0, 1'b0, "sw102");
    idle_cycles(1);

    // Load that is never granted times out on the 4th request cycle.
    s0 = stall_tot; r0 = req_tot; e0 = err_tot;
    apply_stimulus(1'b0, 1'b1, 32'h300, 32'd0, 3'b010, -1, -1, 32'd0, 1'b0, "lw_to");
    check_output("lw_to_errs",   32'(err_tot - e0), 32'd1);
    check_output("lw_to_stalls", 32'(stall_tot - s0), 32'd5);
    check_output("lw_to_reqs",   32'(req_tot - r0), 32'd4);
    check_output("lw_to_rdata",  read_data_m_o, 32'd0);
    idle_cycles(1);

    // Store half to 0x102 after two ungranted cycles.
    apply_stimulus(1'b1, 1'b0, 32'h102, 32'h1234CDEF, 3'b001, 2, -1, 32'd0, 1'b0, "sh102");
    check_output("sh102_be",    32'(snap_be), 32'hC);
    check_output("sh102_wdata", snap_wdata, 32'hCDEFCDEF);

    // Successful byte load, then one whose data never comes back.
    apply_stimulus(1'b0, 1'b1, 32'h003, 32'd0, 3'b100, 0, 0, 32'hA1B2C3D4, 1'b0, "lb003");
    check_output("lb003_be",    32'(snap_be), 32'h8);
    check_output("lb003_rdata", read_data_m_o, 32'hA1B2C3D4);
    e0 = err_tot;
    apply_stimulus(1'b0, 1'b1, 32'h001, 32'd0, 3'b000, 0, -1, 32'd0, 1'b0, "lb_wto");
    check_output("lb_wto_errs",  32'(err_tot - e0), 32'd1);
    check_output("lb_wto_rdata", read_data_m_o, 32'd0);

    // Read and write both high is a store; width 11 behaves as word.
    apply_stimulus(1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 3'b011, 0, -1, 32'd0, 1'b0, "both");
    check_output("both_we", 32'(snap_we), 32'h1);
    check_output("both_be", 32'(snap_be), 32'hF);
    idle_cycles(1);

    // Back-to-back store then load.
    s0 = stall_tot; r0 = req_tot;
    apply_stimulus(1'b1, 1'b0, 32'h500, 32'h11112222, 3'b010, 0, -1, 32'd0, 1'b0, "b2b_st");
    apply_stimulus(1'b0, 1'b1, 32'h504, 32'd0, 3'b010, 0, 0, 32'h33334444, 1'b0, "b2b_ld");
    check_output("b2b_reqs",   32'(req_tot - r0), 32'd2);
    check_output("b2b_stalls", 32'(stall_tot - s0), 32'd5);
    check_output("b2b_addr",   snap_addr, 32'h504);
    check_output("b2b_rdata",  read_data_m_o, 32'h33334444);
    idle_cycles(2);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
LSU_BUS_BRIDGE -- requirements
Module: lsu_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, which sets the cycles allowed in REQ+WAIT before abort (range 1..255).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port valid_m_i, input, 1 bit: the memory-stage instruction is valid.
REQ-005 SHALL have ports mem_write_m_i and mem_read_m_i, input, 1 bit each: store request and load request; both high is treated as a store.
REQ-006 SHALL have port alu_result_m_i, input, 32 bits: byte address.
REQ-007 SHALL have port write_data_m_i, input, 32 bits: store data, LSB-aligned.
REQ-008 SHALL have port width_src_m_i, input, 3 bits: bits[1:0] 00=byte, 01=half, 10=word, 11=treated as word; bit2 is ignored here.
REQ-009 SHALL have outputs bus_req_o (1), bus_we_o (1), bus_addr_o (32, word-aligned, [1:0]=0), bus_wdata_o (32) and bus_be_o (4).
REQ-010 SHALL have inputs bus_gnt_i (1), bus_rvalid_i (1) and bus_rdata_i (32).
REQ-011 SHALL have outputs read_data_m_o (32, raw load word), stall_m_o (1), misalign_o (1) and bus_err_o (1).

Function
REQ-012 SHALL implement the FSM states IDLE, REQ, WAIT and DONE.
REQ-013 SHALL define an access as valid_m_i & (mem_write_m_i | mem_read_m_i) while in IDLE.
REQ-014 SHALL flag a misaligned access when it is a half with addr[0]=1 or a word with addr[1:0]≠0: misalign_o=1 combinationally that cycle, no bus request, stall_m_o=0, and the state stays IDLE.
REQ-015 SHALL, on an aligned access in IDLE, drive stall_m_o=1 combinationally, register the address, be, wdata and we, and go to REQ the next cycle.
REQ-016 SHALL compute byte enables as: byte be=0001<<addr[1:0]; half be=0011<<(2*addr[1]); word be=1111.
REQ-017 SHALL replicate store data across lanes: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-018 SHALL, in REQ, hold bus_req_o=1 with stable addr, we, be and wdata until bus_gnt_i=1; the transfer occurs on the cycle with req&gnt.
REQ-019 SHALL, on the grant of a store, go to DONE, which makes stores posted with no response expected.
REQ-020 SHALL, on the grant of a load, go to WAIT; bus_req_o=0 from the next cycle.
REQ-021 SHALL, in WAIT, capture bus_rdata_i into read_data_m_o on bus_rvalid_i=1 and go to DONE; rvalid in any other state is ignored.
REQ-022 SHALL hold stall_m_o=1 throughout REQ and WAIT.
REQ-023 SHALL, in DONE, drive stall_m_o=0 for exactly one cycle with read_data_m_o stable, then return to IDLE unconditionally, so the same instruction is never re-issued.
REQ-024 SHALL clear the timeout counter (8 bits) on entry to REQ, increment it each cycle in REQ or WAIT, and saturate.
REQ-025 SHALL, when the counter equals TIMEOUT-1 and the pending event (gnt in REQ, rvalid in WAIT) is absent, pulse bus_err_o=1 for one cycle, drop bus_req_o, set read_data_m_o=0 and go to DONE.
REQ-026 SHALL give a success event priority over timeout when both occur in the same cycle.
REQ-027 SHALL keep read_data_m_o holding its last captured value outside DONE.
REQ-028 SHALL ignore valid_m_i and the stage inputs while not in IDLE; the access is the latched copy.

Reset
REQ-029 SHALL, on reset_i=0 at a clock edge: state=IDLE, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=0, read_data_m_o=0, counter=0, bus_err_o=0, misalign_o=0 and stall_m_o=0.
REQ-030 SHALL, on reset asserted in REQ or WAIT, drop bus_req_o on the next cycle and ignore any later rvalid from the aborted transfer.

Verification
REQ-031 SHALL be verified with a store byte to addr 0x103, wd=0x000000AB, gnt the cycle after req -> be=1000, wdata=0xABABABAB, addr=0x100, stall for 2 cycles, DONE for 1.
REQ-032 SHALL be verified with a load word to 0x200, gnt after 3 cycles, rvalid 2 cycles after gnt, rdata=0x12345678 -> read_data_m_o=0x12345678 in DONE, stall_m_o=0 only in DONE.
REQ-033 SHALL be verified with a half load at 0x201 -> misalign_o=1 for one cycle, bus_req_o never asserted, stall_m_o=0.
REQ-034 SHALL be verified with TIMEOUT=4, a load with gnt never asserted -> bus_err_o pulse on the 4th REQ cycle, read_data_m_o=0, then DONE then IDLE.
REQ-035 SHALL be verified with a load granted, then reset_i=0 in WAIT, then rvalid -> all outputs at reset values, rvalid ignored, stall_m_o=0.
REQ-036 SHALL be verified with back-to-back store then load, each granted immediately -> two distinct bus transfers, no duplicate issue, exactly one DONE per access.
